// File: rtl/rapcla_pkg.sv
// Shared RAPCLA definitions: group count, parameter legality check, result bundle layout.
// Bundle is {err_flag, cout, sum[SIZE-1:0]}, so it is SIZE+2 bits wide.
`define RAPCLA_CHECK_PARAMS(SZ, GS, WIN, STG) \
  if (((SZ) % (GS)) != 0 || (WIN) < 1 || (WIN) > (GS) || (STG) < 1 || (STG) > 4) begin : g_bad_params \
    $error("rapcla: illegal SIZE/GROUPSIZE/WINDOW/STAGES combination"); \
  end

package rapcla_pkg;

  function automatic int calc_ng(input int size, input int groupsize);
    return size / groupsize;
  endfunction

  function automatic int res_w(input int size);
    return size + 2;
  endfunction

  function automatic int cout_bit(input int size);
    return size;
  endfunction

  function automatic int err_bit(input int size);
    return size + 1;
  endfunction

endpackage

// File: rtl/rapcla_core_v.sv
// Combinational approximate CLA: per-group exact or window-speculated carry, plus exact reference sum.
// Zero latency, no flow control.
module rapcla_core_v
  import rapcla_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4,
  localparam int NG       = calc_ng(SIZE, GROUPSIZE)
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic [NG-1:0]   rcon,
  output logic [SIZE-1:0] approx_sum,
  output logic            approx_cout,
  output logic [SIZE-1:0] exact_sum,
  output logic            exact_cout
);

  logic                 carry;
  logic [GROUPSIZE:0]   gsum;
  logic [WINDOW:0]      wsum;

  // Speculated carry ignores everything below the window: carry-in to the window is taken as 0.
  always_comb begin
    carry      = cin;
    gsum       = '0;
    wsum       = '0;
    approx_sum = '0;
    for (int g = 0; g < NG; g++) begin
      gsum = {1'b0, a[g*GROUPSIZE +: GROUPSIZE]} + {1'b0, b[g*GROUPSIZE +: GROUPSIZE]}
           + {{GROUPSIZE{1'b0}}, carry};
      wsum = {1'b0, a[g*GROUPSIZE+GROUPSIZE-WINDOW +: WINDOW]}
           + {1'b0, b[g*GROUPSIZE+GROUPSIZE-WINDOW +: WINDOW]};
      approx_sum[g*GROUPSIZE +: GROUPSIZE] = gsum[GROUPSIZE-1:0];
      carry = rcon[g] ? wsum[WINDOW] : gsum[GROUPSIZE];
    end
    approx_cout = carry;
  end

  assign {exact_cout, exact_sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};

endmodule

// File: rtl/rapcla_pipe_v.sv
// Pipelined approximate adder with error monitor; latency STAGES cycles, 1 result/cycle.
// Valid/ready on both sides; a stalled stage holds its bundle, IN_READY drops once the pipe is full.
module rapcla_pipe_v
  import rapcla_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4,
  parameter int STAGES    = 2,
  parameter int CNTW      = 16,
  localparam int NG       = calc_ng(SIZE, GROUPSIZE)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [SIZE:1]   A,
  input  logic [SIZE:1]   B,
  input  logic            CIN,
  input  logic [NG:1]     APPROXRCON,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [SIZE:1]   SUM,
  output logic            COUT,
  output logic            ERR_FLAG,
  input  logic            CLR_CNT,
  output logic [CNTW-1:0] ERR_CNT,
  output logic [CNTW-1:0] OP_CNT
);

  localparam int RW     = res_w(SIZE);
  localparam int COUT_B = cout_bit(SIZE);
  localparam int ERR_B  = err_bit(SIZE);

  `RAPCLA_CHECK_PARAMS(SIZE, GROUPSIZE, WINDOW, STAGES)

  logic [SIZE-1:0]   approx_sum;
  logic [SIZE-1:0]   exact_sum;
  logic              approx_cout;
  logic              exact_cout;
  logic [RW-1:0]     res_in;
  logic [STAGES-1:0] v;
  logic [RW-1:0]     d [STAGES];
  logic [STAGES-1:0] rdy;
  logic              rdy_chain;
  logic              xfer;

  rapcla_core_v #(
    .SIZE      (SIZE),
    .GROUPSIZE (GROUPSIZE),
    .WINDOW    (WINDOW)
  ) u_core (
    .a           (A),
    .b           (B),
    .cin         (CIN),
    .rcon        (APPROXRCON),
    .approx_sum  (approx_sum),
    .approx_cout (approx_cout),
    .exact_sum   (exact_sum),
    .exact_cout  (exact_cout)
  );

  assign res_in = {({approx_cout, approx_sum} != {exact_cout, exact_sum}), approx_cout, approx_sum};

  // A stage can take new data when it is empty or its occupant moves on this cycle.
  always_comb begin
    rdy_chain = OUT_READY;
    rdy       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy_chain = !v[i] || rdy_chain;
      rdy[i]    = rdy_chain;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      if (rdy[0]) begin
        v[0] <= IN_VALID;
        if (IN_VALID) d[0] <= res_in;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = v[STAGES-1];
  assign SUM       = d[STAGES-1][SIZE-1:0];
  assign COUT      = d[STAGES-1][COUT_B];
  assign ERR_FLAG  = d[STAGES-1][ERR_B];
  assign xfer      = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR_CNT) begin
      OP_CNT  <= '0;
      ERR_CNT <= '0;
    end else if (xfer) begin
      if (OP_CNT != '1) OP_CNT <= OP_CNT + 1'b1;
      if (ERR_FLAG && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_rapcla_pipe_v.sv
// Bench for rapcla_pipe_v: directed vectors, backpressure, random traffic against a queue model,
// mid-flight reset and counter saturation/clear (counters built 4 bits wide).
module tb_rapcla_pipe_v;

  localparam int SIZE = 16;
  localparam int GS   = 8;
  localparam int W    = 4;
  localparam int ST   = 2;
  localparam int CW   = 4;
  localparam int NG   = SIZE / GS;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     a;
  logic [15:0]     b;
  logic            cin;
  logic [1:0]      rcon;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     sum;
  logic            cout;
  logic            err_flag;
  logic            clr_cnt;
  logic [CW-1:0]   err_cnt;
  logic [CW-1:0]   op_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_op   = 0;
  int exp_err  = 0;
  logic [17:0] q[$];

  rapcla_pipe_v #(
    .SIZE(SIZE), .GROUPSIZE(GS), .WINDOW(W), .STAGES(ST), .CNTW(CW)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .CIN(cin), .APPROXRCON(rcon),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SUM(sum), .COUT(cout), .ERR_FLAG(err_flag),
    .CLR_CNT(clr_cnt), .ERR_CNT(err_cnt), .OP_CNT(op_cnt)
  );

  always #5 clk = ~clk;

  // Reference: add group by group; a speculated group guesses its carry from the top W bits only.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic [1:0] mr);
    int carry, ga, gb, t, s, exact, approx;
    logic [16:0] ap;
    carry = int'(mc);
    s = 0;
    for (int g = 0; g < NG; g++) begin
      ga = (int'(ma) >> (g * GS)) & ((1 << GS) - 1);
      gb = (int'(mb) >> (g * GS)) & ((1 << GS) - 1);
      t  = ga + gb + carry;
      s  = s | ((t & ((1 << GS) - 1)) << (g * GS));
      if (mr[g]) carry = (((ga >> (GS - W)) + (gb >> (GS - W))) >> W) & 1;
      else       carry = t >> GS;
    end
    approx = (carry << SIZE) | s;
    exact  = int'(ma) + int'(mb) + int'(mc);
    ap     = approx[16:0];
    return {approx != exact, ap};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_xfer(input logic e);
    if (exp_op < CMAX) exp_op++;
    if (e && exp_err < CMAX) exp_err++;
  endtask

  task automatic randomize_operands();
    a    = 16'($urandom);
    b    = 16'($urandom);
    cin  = 1'($urandom);
    rcon = 2'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    a = '0; b = '0; cin = 1'b0; rcon = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sum !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h want=0000", sum); end
    checks++; if ({cout, err_flag} !== 2'b00) begin failures++; $display("FAIL reset_cout_err got=%b want=00", {cout, err_flag}); end
    checks++; if (op_cnt !== '0) begin failures++; $display("FAIL reset_op_cnt got=%0d want=0", op_cnt); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    exp_op = 0; exp_err = 0;
  endtask

  task automatic test_vectors();
    logic [15:0] va [4] = '{16'h01E8, 16'h01E8, 16'hF1E0, 16'hF1E0};
    logic [15:0] vb [4] = '{16'h011F, 16'h011F, 16'hF000, 16'hF000};
    logic [1:0]  vr [4] = '{2'b00, 2'b11, 2'b00, 2'b11};
    logic [15:0] vs [4] = '{16'h0308, 16'h0208, 16'hE1E1, 16'hE1E1};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        ve [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          ve_cnt [4] = '{0, 1, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; cin = 1'b1; rcon = vr[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_early_valid got=%b want=0", i, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_latency got=%b want=1", i, out_valid); end
      checks++;
      if ({err_flag, cout, sum} !== {ve[i], vc[i], vs[i]}) begin
        failures++;
        $display("FAIL vec%0d_result got err=%b cout=%b sum=%h want err=%b cout=%b sum=%h",
                 i, err_flag, cout, sum, ve[i], vc[i], vs[i]);
      end
      count_xfer(ve[i]);
      tick();
      checks++; if (int'(op_cnt) !== i + 1) begin failures++; $display("FAIL vec%0d_op_cnt got=%0d want=%0d", i, op_cnt, i + 1); end
      checks++; if (int'(err_cnt) !== ve_cnt[i]) begin failures++; $display("FAIL vec%0d_err_cnt got=%0d want=%0d", i, err_cnt, ve_cnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      randomize_operands();
      in_valid = 1'b1;
      #1;
      if (in_ready) begin acc++; q.push_back(model(a, b, cin, rcon)); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (acc !== ST) begin failures++; $display("FAIL bp_accepted got=%0d want=%0d", acc, ST); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < ST; i++) begin
      checks++;
      if (out_valid !== 1'b1 || q.size() == 0 || {err_flag, cout, sum} !== q[0]) begin
        failures++;
        $display("FAIL bp_drain%0d got valid=%b data=%h want valid=1 data=%h", i, out_valid,
                 {err_flag, cout, sum}, (q.size() != 0) ? q[0] : 18'h0);
      end
      if (q.size() != 0) begin count_xfer(q[0][17]); void'(q.pop_front()); end
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin randomize_operands(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (k < 10) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL tput_in_ready k=%0d got=%b want=1", k, in_ready); end
        q.push_back(model(a, b, cin, rcon));
      end
      checks++;
      if ((k >= ST) !== out_valid) begin failures++; $display("FAIL tput_out_valid k=%0d got=%b want=%b", k, out_valid, k >= ST); end
      if (out_valid && q.size() != 0) begin
        checks++;
        if ({err_flag, cout, sum} !== q[0]) begin
          failures++; $display("FAIL tput_data k=%0d got=%h want=%h", k, {err_flag, cout, sum}, q[0]);
        end
        count_xfer(q[0][17]);
        void'(q.pop_front());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic acc, del;
    for (int n = 0; n < 400; n++) begin
      randomize_operands();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      clr_cnt   = ($urandom % 25) == 0;
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_unexpected n=%0d got=%h want=none", n, {err_flag, cout, sum});
        end else begin
          if ({err_flag, cout, sum} !== q[0]) begin
            failures++; $display("FAIL rand_data n=%0d got=%h want=%h", n, {err_flag, cout, sum}, q[0]);
          end
          if (!clr_cnt) count_xfer(q[0][17]);
          void'(q.pop_front());
        end
      end
      if (clr_cnt) begin exp_op = 0; exp_err = 0; end
      if (acc) q.push_back(model(a, b, cin, rcon));
      tick();
      checks++;
      if (int'(op_cnt) !== exp_op || int'(err_cnt) !== exp_err) begin
        failures++;
        $display("FAIL rand_counters n=%0d got op=%0d err=%0d want op=%0d err=%0d", n, op_cnt, err_cnt, exp_op, exp_err);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (out_valid && q.size() != 0) begin
        checks++;
        if ({err_flag, cout, sum} !== q[0]) begin
          failures++; $display("FAIL rand_drain got=%h want=%h", {err_flag, cout, sum}, q[0]);
        end
        count_xfer(q[0][17]);
        void'(q.pop_front());
      end
      tick();
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d pending want=0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    int bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin randomize_operands(); in_valid = 1'b1; tick(); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (op_cnt !== '0 || err_cnt !== '0) begin failures++; $display("FAIL midrst_counters got op=%0d err=%0d want 0 0", op_cnt, err_cnt); end
    q.delete(); exp_op = 0; exp_err = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid) bad++;
      tick();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_stale got=%0d deliveries want=0", bad); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    a = 16'h01E8; b = 16'h011F; cin = 1'b1; rcon = 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (op_cnt !== 4'hF) begin failures++; $display("FAIL sat_op_cnt got=%h want=f", op_cnt); end
    checks++; if (err_cnt !== 4'hF) begin failures++; $display("FAIL sat_err_cnt got=%h want=f", err_cnt); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_setup_valid got=%b want=1", out_valid); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (op_cnt !== '0 || err_cnt !== '0) begin failures++; $display("FAIL clr_wins got op=%0d err=%0d want 0 0", op_cnt, err_cnt); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (op_cnt !== 4'd1 || err_cnt !== 4'd1) begin failures++; $display("FAIL post_clr_count got op=%0d err=%0d want 1 1", op_cnt, err_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
